matrix_store_alloc: RTL and testbench
=====================================

// Module: matrix_store_alloc
// PURPOSE
//  Matrix storage manager directly downstream of the UART input subsystem.
//  - Serves the dims/addr handshake: alloc_req/alloc_m/alloc_n in, alloc_base/alloc_ready out.
//  - Owns the matrix RAM and absorbs the input stage's write stream (wr_en/wr_addr/wr_data).
//  - Keeps per-slot shape metadata for the display and compute stages.
// PARAMETERS
//  SLOTS        8   number of matrix slots
//  SLOT_WORDS   25  words per slot (5x5 max); slot i base = i*SLOT_WORDS
//  DATA_W       32  element width
//  MAX_PER_SHAPE 2  max live slots sharing one (m,n) shape
//  ADDR_W       8   RAM address width; SLOTS*SLOT_WORDS <= 2**ADDR_W
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  alloc_req    in   1       level; held high by requester until alloc_ready seen
//  alloc_m      in   32      rows, legal 1..5
//  alloc_n      in   32      cols, legal 1..5
//  alloc_ready  out  1       1-cycle pulse: alloc_base/alloc_slot valid
//  alloc_base   out  ADDR_W  base address of granted slot
//  alloc_slot   out  3       granted slot index
//  alloc_err    out  1       1-cycle pulse: dims out of range, no grant
//  wr_en        in   1       write strobe
//  wr_addr      in   ADDR_W  absolute write address
//  wr_data      in   DATA_W  write data
//  wr_err       out  1       1-cycle pulse: wr_addr >= SLOTS*SLOT_WORDS, write dropped
//  rd_addr      in   ADDR_W  read address
//  rd_data      out  DATA_W  registered read data, latency 1
//  qry_slot     in   3       metadata query index
//  qry_valid/qry_m/qry_n/qry_base  out 1/3/3/ADDR_W  registered slot info, latency 1
//  num_valid    out  4       count of live slots
//  busy         out  1       FSM not in S_IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; all slot valid bits 0; rr_ptr 0; FSM S_IDLE. RAM contents not reset.
//  - FSM states and transitions:
//    - S_IDLE -> S_CHECK when alloc_req=1.
//    - S_CHECK:
//      - if alloc_m or alloc_n is outside 1..5: alloc_err=1, -> S_HOLD.
//      - otherwise clear scan regs, -> S_SCAN.
//    - S_SCAN: examines one slot per cycle, idx 0..SLOTS-1, and records:
//      - first free slot;
//      - lowest-index live slot whose shape equals (m,n);
//      - count of same-shape live slots.
//    - S_SCAN exit after idx SLOTS-1; victim choice, in priority:
//      - same_cnt >= MAX_PER_SHAPE: the lowest same-shape slot;
//      - else first free slot;
//      - else slot rr_ptr, and rr_ptr <= rr_ptr+1 (wraps at SLOTS).
//    - After victim choice: -> S_CLEAR if MATRIX_ALLOC_CLEAR_EN, else -> S_GRANT.
//    - S_GRANT: alloc_ready=1 for exactly one cycle; victim metadata <= {valid=1,m,n}; -> S_HOLD.
//    - S_HOLD: wait for alloc_req=0, then -> S_IDLE.
//      - Required because the requester drops req one cycle after ready.
//      - Guarantees exactly one grant per request.
//  - Latency, req rise to alloc_ready: 2+SLOTS cycles (10 at default), plus SLOT_WORDS when clearing.
//  - alloc_base = slot*SLOT_WORDS; the multiply is constant, computed at victim choice; held until next grant.
//  - Writes:
//    - accepted every cycle, in any FSM state;
//    - address in range: RAM write next edge;
//    - wr_en with out-of-range address: no write, wr_err pulse.
//  - Read during write, same address: rd_data returns old data (read-first).
//  - Dims truncated to 3 bits only after range check passes.
//  - num_valid updates the cycle after grant; never exceeds SLOTS.
//  - alloc_req dropped mid-scan: the scan completes and metadata is written anyway; no retraction.
//  - Reset mid-operation: FSM to S_IDLE immediately; pulses 0.
// CONFIGURATION
//  MATRIX_ALLOC_CLEAR_EN defined:
//    - S_CLEAR zero-fills the victim's SLOT_WORDS words, one per cycle, then -> S_GRANT.
//    - An external wr_en arriving during S_CLEAR is performed and the clear word is skipped that cycle.
//  MATRIX_ALLOC_CLEAR_EN undefined:
//    - S_CLEAR absent; victim contents are left stale; the requester is responsible for pre-clear.
// TESTING
//  1. Reset, alloc_req with m=2,n=3 held until ready:
//     -> alloc_ready once at cycle 10 (no CLEAR), alloc_base=0, slot 0; qry_slot=0 -> valid,m=2,n=3.
//  2. Three allocs at 2x2:
//     -> slots 0, 1, then 0 again (MAX_PER_SHAPE=2), base 0; num_valid=2.
//  3. Fill 8 distinct-shape slots, then alloc 1x1:
//     -> slot rr_ptr=0 reused; the following alloc 5x5 -> slot 1.
//  4. alloc_m=6 -> alloc_err pulse, no alloc_ready, num_valid unchanged; alloc_m=0 gives the same result.
//  5. wr_en addr=27 data=7, then rd_addr=27 -> rd_data=7 next cycle; wr_en addr=200 -> wr_err=1, RAM unchanged.
//  6. CLEAR_EN build:
//     - slot 1 preloaded with 9s, realloc forced onto it;
//     - -> words 25..49 read 0, alloc_ready at cycle 35;
//     - assert rst_n low mid-S_CLEAR -> busy=0 next cycle.

Source files
------------

// File: rtl/matrix_store_alloc_if.sv
// ----------------------------------------------------------------------------
// matrix_store_alloc_if
// Purpose : bundles the allocation handshake and the input-stage write stream
//           between the UART input subsystem (master) and the matrix store
//           (slave).
// Signals :
//   alloc_req   master->slave  level request, held until alloc_ready/alloc_err
//   alloc_m     master->slave  requested rows (legal 1..5)
//   alloc_n     master->slave  requested cols (legal 1..5)
//   alloc_ready slave->master  1-cycle pulse, alloc_base/alloc_slot valid
//   alloc_base  slave->master  base address of the granted slot
//   alloc_slot  slave->master  granted slot index
//   alloc_err   slave->master  1-cycle pulse, dims rejected, no grant
//   wr_en       master->slave  write strobe
//   wr_addr     master->slave  absolute RAM write address
//   wr_data     master->slave  write data
//   wr_err      slave->master  1-cycle pulse, write address out of range
// ----------------------------------------------------------------------------
interface matrix_store_alloc_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              alloc_req;
   logic [31:0]       alloc_m;
   logic [31:0]       alloc_n;
   logic              alloc_ready;
   logic [ADDR_W-1:0] alloc_base;
   logic [2:0]        alloc_slot;
   logic              alloc_err;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_err;

   modport master (
      output alloc_req, alloc_m, alloc_n, wr_en, wr_addr, wr_data,
      input  alloc_ready, alloc_base, alloc_slot, alloc_err, wr_err
   );

   modport slave (
      input  alloc_req, alloc_m, alloc_n, wr_en, wr_addr, wr_data,
      output alloc_ready, alloc_base, alloc_slot, alloc_err, wr_err
   );
endinterface

// File: rtl/matrix_store_alloc.sv
// ----------------------------------------------------------------------------
// matrix_store_alloc
// Purpose : matrix storage manager behind the UART input stage. Grants matrix
//           slots on request (dims/addr handshake), owns the matrix RAM that
//           the input stage writes into, and keeps per-slot shape metadata
//           for the display and compute stages.
// Ports   :
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     alloc handshake + write stream, see matrix_store_alloc_if
//   rd_addr_i       RAM read address
//   rd_data_o       registered read data, latency 1, read-first
//   qry_slot_i      metadata query index
//   qry_valid_o/qry_m_o/qry_n_o/qry_base_o  registered slot info, latency 1
//   num_valid_o     number of live slots
//   busy_o          allocation FSM not idle
// Build option:
//   MATRIX_ALLOC_CLEAR_EN  when defined, the victim slot is zero-filled
//                          (one word per cycle) before the grant.
// ----------------------------------------------------------------------------
module matrix_store_alloc #(
   parameter int SLOTS         = 8,
   parameter int SLOT_WORDS    = 25,
   parameter int DATA_W        = 32,
   parameter int MAX_PER_SHAPE = 2,
   parameter int ADDR_W        = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   matrix_store_alloc_if.slave  bus,
   input  logic [ADDR_W-1:0]    rd_addr_i,
   output logic [DATA_W-1:0]    rd_data_o,
   input  logic [2:0]           qry_slot_i,
   output logic                 qry_valid_o,
   output logic [2:0]           qry_m_o,
   output logic [2:0]           qry_n_o,
   output logic [ADDR_W-1:0]    qry_base_o,
   output logic [3:0]           num_valid_o,
   output logic                 busy_o
);

   localparam int TOTAL = SLOTS * SLOT_WORDS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_SCAN,
`ifdef MATRIX_ALLOC_CLEAR_EN
      S_CLEAR,
`endif
      S_GRANT,
      S_HOLD
   } state_t;

   state_t state_q, state_d;

   logic [2:0]        idx_q, freeIdx_q, freeIdx_d, sameIdx_q, sameIdx_d;
   logic              freeFound_q, freeFound_d, sameFound_q, sameFound_d;
   logic [3:0]        sameCnt_q, sameCnt_d;
   logic [2:0]        reqM_q, reqN_q;
   logic [2:0]        victim_q, victimSel;
   logic              useRr;
   logic [ADDR_W-1:0] base_q;
   logic [2:0]        rrPtr_q;
   logic [SLOTS-1:0]  slotValid_q;
   logic [2:0]        slotM_q [SLOTS];
   logic [2:0]        slotN_q [SLOTS];
   logic              dimsBad, lastIdx, hit, wrInRange;
   logic              ramWe;
   logic [ADDR_W-1:0] ramAddr;
   logic [DATA_W-1:0] ramData;
   logic [DATA_W-1:0] mem [TOTAL];
   logic [DATA_W-1:0] rdData_q;
   logic              wrErr_q;
   logic              qryValid_q;
   logic [2:0]        qryM_q, qryN_q;
   logic [ADDR_W-1:0] qryBase_q;
   logic [3:0]        liveCnt;
`ifdef MATRIX_ALLOC_CLEAR_EN
   logic [4:0]        clrIdx_q;
`endif

   function automatic logic [ADDR_W-1:0] slotBase(input logic [2:0] s);
      return ADDR_W'(int'(s) * SLOT_WORDS);
   endfunction

   // Range check works on the full 32-bit dims so that large values whose low
   // bits happen to look legal are still rejected.
   assign dimsBad = (bus.alloc_m == 32'd0) || (bus.alloc_m > 32'd5) ||
                    (bus.alloc_n == 32'd0) || (bus.alloc_n > 32'd5);
   assign lastIdx   = (idx_q == 3'(SLOTS - 1));
   assign wrInRange = (bus.wr_addr < ADDR_W'(TOTAL));

   // One scan step: fold the slot under idx_q into the running results, and
   // from the folded results pick the victim so the choice is ready on the
   // final scan cycle without an extra state.
   always_comb begin
      hit         = slotValid_q[idx_q] && (slotM_q[idx_q] == reqM_q) &&
                    (slotN_q[idx_q] == reqN_q);
      freeFound_d = freeFound_q;
      freeIdx_d   = freeIdx_q;
      sameFound_d = sameFound_q;
      sameIdx_d   = sameIdx_q;
      sameCnt_d   = sameCnt_q;
      if (!slotValid_q[idx_q] && !freeFound_q) begin
         freeFound_d = 1'b1;
         freeIdx_d   = idx_q;
      end
      if (hit) begin
         sameCnt_d = sameCnt_q + 4'd1;
         if (!sameFound_q) begin
            sameFound_d = 1'b1;
            sameIdx_d   = idx_q;
         end
      end
      useRr = 1'b0;
      if (sameCnt_d >= 4'(MAX_PER_SHAPE)) begin
         victimSel = sameIdx_d;
      end else if (freeFound_d) begin
         victimSel = freeIdx_d;
      end else begin
         victimSel = rrPtr_q;
         useRr     = 1'b1;
      end
   end

   // FSM state register; reset drops straight back to idle from any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic. HOLD waits for the requester to drop alloc_req so
   // a single request can never be granted twice.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.alloc_req) state_d = S_CHECK;
         S_CHECK: state_d = dimsBad ? S_HOLD : S_SCAN;
         S_SCAN: begin
            if (lastIdx) begin
`ifdef MATRIX_ALLOC_CLEAR_EN
               state_d = S_CLEAR;
`else
               state_d = S_GRANT;
`endif
            end
         end
`ifdef MATRIX_ALLOC_CLEAR_EN
         S_CLEAR: if (clrIdx_q == 5'(SLOT_WORDS - 1)) state_d = S_GRANT;
`endif
         S_GRANT: state_d = S_HOLD;
         S_HOLD:  if (!bus.alloc_req) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs. Grant/err pulses come straight from the state so they are
   // exactly one cycle wide and vanish the instant reset is asserted.
   always_comb begin
      bus.alloc_ready = (state_q == S_GRANT);
      bus.alloc_err   = (state_q == S_CHECK) && dimsBad;
      bus.alloc_base  = base_q;
      bus.alloc_slot  = victim_q;
      busy_o          = (state_q != S_IDLE);
   end

   // Allocation datapath: latch truncated dims after the range check, run
   // the scan, capture victim/base at scan exit, commit metadata at grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         freeFound_q <= 1'b0;
         freeIdx_q   <= '0;
         sameFound_q <= 1'b0;
         sameIdx_q   <= '0;
         sameCnt_q   <= '0;
         reqM_q      <= '0;
         reqN_q      <= '0;
         victim_q    <= '0;
         base_q      <= '0;
         rrPtr_q     <= '0;
         slotValid_q <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            slotM_q[i] <= '0;
            slotN_q[i] <= '0;
         end
`ifdef MATRIX_ALLOC_CLEAR_EN
         clrIdx_q    <= '0;
`endif
      end else begin
         case (state_q)
            S_CHECK: begin
               if (!dimsBad) begin
                  reqM_q      <= bus.alloc_m[2:0];
                  reqN_q      <= bus.alloc_n[2:0];
                  idx_q       <= '0;
                  freeFound_q <= 1'b0;
                  freeIdx_q   <= '0;
                  sameFound_q <= 1'b0;
                  sameIdx_q   <= '0;
                  sameCnt_q   <= '0;
               end
            end
            S_SCAN: begin
               idx_q       <= idx_q + 3'd1;
               freeFound_q <= freeFound_d;
               freeIdx_q   <= freeIdx_d;
               sameFound_q <= sameFound_d;
               sameIdx_q   <= sameIdx_d;
               sameCnt_q   <= sameCnt_d;
               if (lastIdx) begin
                  victim_q <= victimSel;
                  base_q   <= slotBase(victimSel);
                  if (useRr) rrPtr_q <= (rrPtr_q == 3'(SLOTS - 1)) ? 3'd0 : rrPtr_q + 3'd1;
`ifdef MATRIX_ALLOC_CLEAR_EN
                  clrIdx_q <= '0;
`endif
               end
            end
`ifdef MATRIX_ALLOC_CLEAR_EN
            S_CLEAR: clrIdx_q <= clrIdx_q + 5'd1;
`endif
            S_GRANT: begin
               slotValid_q[victim_q] <= 1'b1;
               slotM_q[victim_q]     <= reqM_q;
               slotN_q[victim_q]     <= reqN_q;
            end
            default: ;
         endcase
      end
   end

   // RAM write port. External writes always win; in clear builds the zero
   // fill uses the port only on cycles the input stage leaves it idle, and
   // that clear word is simply skipped otherwise.
   always_comb begin
      ramWe   = bus.wr_en && wrInRange;
      ramAddr = bus.wr_addr;
      ramData = bus.wr_data;
`ifdef MATRIX_ALLOC_CLEAR_EN
      if ((state_q == S_CLEAR) && !bus.wr_en) begin
         ramWe   = 1'b1;
         ramAddr = base_q + ADDR_W'(clrIdx_q);
         ramData = '0;
      end
`endif
   end

   // Matrix RAM, deliberately not reset.
   always_ff @(posedge clk) begin
      if (ramWe) mem[ramAddr] <= ramData;
   end

   // Registered read (read-first), write error pulse and metadata query.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdData_q   <= '0;
         wrErr_q    <= 1'b0;
         qryValid_q <= 1'b0;
         qryM_q     <= '0;
         qryN_q     <= '0;
         qryBase_q  <= '0;
      end else begin
         rdData_q   <= (rd_addr_i < ADDR_W'(TOTAL)) ? mem[rd_addr_i] : '0;
         wrErr_q    <= bus.wr_en && !wrInRange;
         qryValid_q <= slotValid_q[qry_slot_i];
         qryM_q     <= slotM_q[qry_slot_i];
         qryN_q     <= slotN_q[qry_slot_i];
         qryBase_q  <= slotBase(qry_slot_i);
      end
   end

   // Live-slot population count.
   always_comb begin
      liveCnt = '0;
      for (int i = 0; i < SLOTS; i++) liveCnt = liveCnt + {3'b000, slotValid_q[i]};
   end

   assign rd_data_o   = rdData_q;
   assign bus.wr_err  = wrErr_q;
   assign qry_valid_o = qryValid_q;
   assign qry_m_o     = qryM_q;
   assign qry_n_o     = qryN_q;
   assign qry_base_o  = qryBase_q;
   assign num_valid_o = liveCnt;

endmodule

// File: tb/tb_matrix_store_alloc.sv
// ----------------------------------------------------------------------------
// tb_matrix_store_alloc
// Randomized + directed bench for matrix_store_alloc. A behavioural model of
// slot allocation and RAM contents predicts every grant; expected grants are
// queued and a negedge monitor checks them as the DUT pulses alloc_ready or
// alloc_err. Define MATRIX_ALLOC_CLEAR_EN to exercise the zero-fill build.
// ----------------------------------------------------------------------------
module tb_matrix_store_alloc;
   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 32;
   localparam int SLOTS      = 8;
   localparam int SLOT_WORDS = 25;
   localparam int TOTAL      = SLOTS * SLOT_WORDS;
`ifdef MATRIX_ALLOC_CLEAR_EN
   localparam int LAT = 2 + SLOTS + SLOT_WORDS;
`else
   localparam int LAT = 2 + SLOTS;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   matrix_store_alloc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc();

   logic [ADDR_W-1:0] rdAddr;
   logic [DATA_W-1:0] rdData;
   logic [2:0]        qrySlot;
   logic              qryValid;
   logic [2:0]        qryM, qryN;
   logic [ADDR_W-1:0] qryBase;
   logic [3:0]        numValid;
   logic              busy;

   matrix_store_alloc #(
      .SLOTS(SLOTS), .SLOT_WORDS(SLOT_WORDS), .DATA_W(DATA_W),
      .MAX_PER_SHAPE(2), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc),
      .rd_addr_i(rdAddr), .rd_data_o(rdData),
      .qry_slot_i(qrySlot), .qry_valid_o(qryValid), .qry_m_o(qryM),
      .qry_n_o(qryN), .qry_base_o(qryBase),
      .num_valid_o(numValid), .busy_o(busy)
   );

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      bit isErr;
      int slot;
   } exp_t;
   exp_t expQ[$];

   // Behavioural model: slot table, round-robin pointer, known RAM words.
   bit          refValid [SLOTS];
   int          refM [SLOTS];
   int          refN [SLOTS];
   int          refRr;
   logic [31:0] refMem [TOTAL];
   bit          known [TOTAL];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int refCount();
      int c = 0;
      for (int i = 0; i < SLOTS; i++) c += refValid[i] ? 1 : 0;
      return c;
   endfunction

   // Pick a slot from the rules: too many same-shape -> lowest same-shape,
   // else lowest free, else round-robin.
   function automatic int pickSlot(input int m, input int n);
      int same = 0, lowSame = -1, firstFree = -1;
      for (int i = 0; i < SLOTS; i++) begin
         if (refValid[i] && refM[i] == m && refN[i] == n) begin
            if (lowSame < 0) lowSame = i;
            same++;
         end else if (!refValid[i] && firstFree < 0) begin
            firstFree = i;
         end
      end
      if (same >= 2) return lowSame;
      if (firstFree >= 0) return firstFree;
      return -1;
   endfunction

   // Grant/err monitor: every pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && (ifc.alloc_ready || ifc.alloc_err)) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_resp", {62'd0, ifc.alloc_ready, ifc.alloc_err}, 64'd0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("resp_is_err", ifc.alloc_err, e.isErr);
            checkOutput("resp_is_ready", ifc.alloc_ready, !e.isErr);
            if (!e.isErr) begin
               checkOutput("grant_slot", ifc.alloc_slot, e.slot);
               checkOutput("grant_base", ifc.alloc_base, e.slot * SLOT_WORDS);
            end
         end
      end
   end

   task automatic doReset();
      rst_n = 1'b0;
      ifc.alloc_req = 1'b0;
      ifc.alloc_m = '0;
      ifc.alloc_n = '0;
      ifc.wr_en = 1'b0;
      ifc.wr_addr = '0;
      ifc.wr_data = '0;
      rdAddr = '0;
      qrySlot = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_alloc_ready", ifc.alloc_ready, 0);
      checkOutput("rst_alloc_err", ifc.alloc_err, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_num_valid", numValid, 0);
      checkOutput("rst_alloc_base", ifc.alloc_base, 0);
      checkOutput("rst_wr_err", ifc.wr_err, 0);
      checkOutput("rst_qry_valid", qryValid, 0);
      checkOutput("rst_rd_data", rdData, 0);
      for (int i = 0; i < SLOTS; i++) refValid[i] = 1'b0;
      refRr = 0;
      expQ.delete();
      rst_n = 1'b1;
   endtask

   // Full request: hold req until a response, drop it one cycle later, wait idle.
   task automatic doAlloc(input logic [31:0] m, input logic [31:0] n);
      exp_t e;
      bit bad;
      bit got = 1'b0;
      int lat = 0;
      bad = (m < 1) || (m > 5) || (n < 1) || (n > 5);
      e.isErr = bad;
      e.slot = 0;
      if (!bad) begin
         e.slot = pickSlot(int'(m), int'(n));
         if (e.slot < 0) begin
            e.slot = refRr;
            refRr = (refRr + 1) % SLOTS;
         end
         refValid[e.slot] = 1'b1;
         refM[e.slot] = int'(m);
         refN[e.slot] = int'(n);
`ifdef MATRIX_ALLOC_CLEAR_EN
         for (int w = 0; w < SLOT_WORDS; w++) begin
            refMem[e.slot * SLOT_WORDS + w] = '0;
            known[e.slot * SLOT_WORDS + w] = 1'b1;
         end
`endif
      end
      expQ.push_back(e);
      ifc.alloc_req = 1'b1;
      ifc.alloc_m = m;
      ifc.alloc_n = n;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (ifc.alloc_ready || ifc.alloc_err) begin
            lat = c;
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL alloc_timeout: no response for m=%0d n=%0d, required one", m, n);
         void'(expQ.pop_back());
      end else begin
         checkOutput("alloc_latency", lat, bad ? 1 : LAT);
      end
      @(posedge clk);
      #1;
      ifc.alloc_req = 1'b0;
      for (int c = 0; c < 20 && busy; c++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("idle_after_alloc", busy, 0);
      checkOutput("num_valid", numValid, refCount());
   endtask

   task automatic doWrite(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
      ifc.wr_en = 1'b1;
      ifc.wr_addr = addr;
      ifc.wr_data = data;
      @(posedge clk);
      #1;
      ifc.wr_en = 1'b0;
      checkOutput("wr_err", ifc.wr_err, (int'(addr) >= TOTAL) ? 1 : 0);
      if (int'(addr) < TOTAL) begin
         refMem[addr] = data;
         known[addr] = 1'b1;
      end
   endtask

   task automatic doRead(input logic [ADDR_W-1:0] addr);
      rdAddr = addr;
      @(posedge clk);
      #1;
      if (int'(addr) < TOTAL && known[addr]) checkOutput("rd_data", rdData, refMem[addr]);
   endtask

   task automatic doQuery(input int s);
      qrySlot = 3'(s);
      @(posedge clk);
      #1;
      checkOutput("qry_valid", qryValid, refValid[s]);
      checkOutput("qry_base", qryBase, s * SLOT_WORDS);
      if (refValid[s]) begin
         checkOutput("qry_m", qryM, refM[s]);
         checkOutput("qry_n", qryN, refN[s]);
      end
   endtask

   task automatic applyStimulus(input int iters);
      for (int k = 0; k < iters; k++) begin
         int op = $urandom_range(0, 9);
         if (op < 5) begin
            doAlloc($urandom_range(0, 6), $urandom_range(0, 6));
         end else if (op < 7) begin
            doWrite(ADDR_W'($urandom_range(0, 255)), $urandom);
         end else if (op < 9) begin
            doRead(ADDR_W'($urandom_range(0, TOTAL - 1)));
         end else begin
            doQuery($urandom_range(0, SLOTS - 1));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < TOTAL; i++) known[i] = 1'b0;

      // Single allocation, then metadata readback.
      doReset();
      doAlloc(2, 3);
      doQuery(0);

      // Same shape three times: third request reuses the lowest same-shape slot.
      doReset();
      doAlloc(2, 2);
      doAlloc(2, 2);
      doAlloc(2, 2);

      // Fill all slots with distinct shapes, then round-robin reuse.
      doReset();
      for (int i = 0; i < SLOTS; i++) doAlloc(1 + i / 5, 1 + i % 5);
      doAlloc(1, 1);
      doAlloc(5, 5);
      doQuery(1);

      // Illegal dims, including large values whose low bits look legal.
      doAlloc(6, 2);
      doAlloc(0, 2);
      doAlloc(3, 0);
      doAlloc(32'h0000_000A, 2);
      doAlloc(2, 32'h8000_0003);

      // RAM: write/read, read-first collision, out-of-range write.
      doWrite(27, 7);
      doRead(27);
      rdAddr = 27;
      doWrite(27, 32'h1234_5678);
      checkOutput("read_first", rdData, 7);
      doRead(27);
      doWrite(200, 32'hDEAD_BEEF);
      doWrite(255, 32'hDEAD_BEEF);
      doRead(27);

`ifdef MATRIX_ALLOC_CLEAR_EN
      // Zero fill of the victim slot, then reset asserted mid-clear.
      doReset();
      for (int w = 0; w < SLOT_WORDS; w++) doWrite(ADDR_W'(SLOT_WORDS + w), 9);
      doRead(ADDR_W'(SLOT_WORDS + 3));
      doAlloc(2, 3);
      doAlloc(4, 4);
      for (int w = 0; w < SLOT_WORDS; w++) doRead(ADDR_W'(SLOT_WORDS + w));
      ifc.alloc_req = 1'b1;
      ifc.alloc_m = 1;
      ifc.alloc_n = 1;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("busy_in_clear", busy, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("busy_after_rst", busy, 0);
      checkOutput("ready_after_rst", ifc.alloc_ready, 0);
      for (int i = 0; i < TOTAL; i++) known[i] = 1'b0;
      doReset();
`endif

      // Randomized mix from a clean state.
      doReset();
      applyStimulus(60);
      for (int s = 0; s < SLOTS; s++) doQuery(s);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("queue_drained", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #800000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
